transmitter: RTL

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/tx_if.sv | 25 ++
 rtl/transmitter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tx_if.sv
// Transmitter host-side bus: baud tick, byte write strobe, serial line and buffer status.
// The master modport is the host/driver side; the slave modport is the transmitter.
interface tx_if;
    logic       txEnable;
    logic [7:0] tx_data;
    logic       load;
    logic       TxD;
    logic       TBR;

    modport master (
        output txEnable,
        output tx_data,
        output load,
        input  TxD,
        input  TBR
    );

    modport slave (
        input  txEnable,
        input  tx_data,
        input  load,
        output TxD,
        output TBR
    );
endinterface

// File: rtl/transmitter.sv
// UART transmitter: 8-bit holding buffer feeding a frame shift register.
// Each bit is held for 16 txEnable ticks and bits go out LSB first.
// Optional macro TX_PARITY_EN adds an even-parity bit after the data (8E1);
// when it is undefined the frame is 8N1.
module transmitter (
    input  logic clk,
    input  logic rst,
    tx_if.slave  bus
);

`ifdef TX_PARITY_EN
    localparam int FRAME_W = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity over the data byte: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    localparam int FRAME_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t               state_r;
    logic [7:0]           buf_r;
    logic                 buf_full_r;
    logic                 tbr_r;
    logic                 txd_r;
    logic [3:0]           tick_r;
    logic [2:0]           bit_idx_r;
    logic [FRAME_W-1:0]   shift_r;
    logic [FRAME_W-1:0]   frame_s;
    logic                 last_tick_s;

    // Frame image in transmit order: bit 0 is the start bit, the top bit is the stop bit.
    always_comb begin
        frame_s = '1;
`ifdef TX_PARITY_EN
        frame_s = {1'b1, even_parity(buf_r), buf_r, 1'b0};
`else
        frame_s = {1'b1, buf_r, 1'b0};
`endif
    end

    // The 16th tick of a bit period: the bit ends on this edge.
    always_comb begin
        last_tick_s = 1'b0;
        if (bus.txEnable && (tick_r == 4'd15)) begin
            last_tick_s = 1'b1;
        end else begin
            last_tick_s = 1'b0;
        end
    end

    // Holding buffer, frame FSM, bit timing and the registered serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            buf_r      <= 8'h00;
            buf_full_r <= 1'b0;
            tbr_r      <= 1'b1;
            txd_r      <= 1'b1;
            tick_r     <= 4'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= '1;
        end else begin
            // A write is only taken while the holding buffer is empty.
            if (bus.load && tbr_r) begin
                buf_r      <= bus.tx_data;
                buf_full_r <= 1'b1;
                tbr_r      <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    txd_r     <= 1'b1;
                    tick_r    <= 4'd0;
                    bit_idx_r <= 3'd0;
                    if (buf_full_r) begin
                        shift_r    <= frame_s;
                        txd_r      <= 1'b0;
                        buf_full_r <= 1'b0;
                        tbr_r      <= 1'b1;
                        state_r    <= START;
                    end
                end
                START: begin
                    if (last_tick_s) begin
                        tick_r    <= 4'd0;
                        bit_idx_r <= 3'd0;
                        shift_r   <= {1'b1, shift_r[FRAME_W-1:1]};
                        txd_r     <= shift_r[1];
                        state_r   <= DATA;
                    end else if (bus.txEnable) begin
                        tick_r <= tick_r + 4'd1;
                    end
                end
                DATA: begin
                    if (last_tick_s) begin
                        tick_r  <= 4'd0;
                        shift_r <= {1'b1, shift_r[FRAME_W-1:1]};
                        txd_r   <= shift_r[1];
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
`ifdef TX_PARITY_EN
                            state_r   <= PARITY;
`else
                            state_r   <= STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else if (bus.txEnable) begin
                        tick_r <= tick_r + 4'd1;
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    if (last_tick_s) begin
                        tick_r    <= 4'd0;
                        bit_idx_r <= 3'd0;
                        shift_r   <= {1'b1, shift_r[FRAME_W-1:1]};
                        txd_r     <= shift_r[1];
                        state_r   <= STOP;
                    end else if (bus.txEnable) begin
                        tick_r <= tick_r + 4'd1;
                    end
                end
`endif
                STOP: begin
                    if (last_tick_s) begin
                        tick_r    <= 4'd0;
                        bit_idx_r <= 3'd0;
                        if (buf_full_r) begin
                            // Next byte already waiting: start bit follows the stop bit directly.
                            shift_r    <= frame_s;
                            txd_r      <= 1'b0;
                            buf_full_r <= 1'b0;
                            tbr_r      <= 1'b1;
                            state_r    <= START;
                        end else begin
                            shift_r <= '1;
                            txd_r   <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else if (bus.txEnable) begin
                        tick_r <= tick_r + 4'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    txd_r     <= 1'b1;
                    tick_r    <= 4'd0;
                    bit_idx_r <= 3'd0;
                    shift_r   <= '1;
                end
            endcase
        end
    end

    assign bus.TxD = txd_r;
    assign bus.TBR = tbr_r;

endmodule
